// File: rtl/mdu_pkg.sv
// Shared types and op-class decode for the sequential multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_mul(input op_e op);
        return ~op[2];
    endfunction

    function automatic logic is_rem(input op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_signed(input op_e op);
        return (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
    endfunction

    function automatic logic b_signed(input op_e op);
        return (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// trial-subtract the divisor and keep the difference only when it does not borrow.
module mdu_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] div,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    assign shifted = {rem, quo[XLEN-1]};
    // Extra guard bit so the borrow is unambiguous even for a zero divisor.
    assign diff    = {1'b0, shifted} - {2'b00, div};
    assign rem_nxt = diff[XLEN+1] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nxt = {quo[XLEN-2:0], ~diff[XLEN+1]};

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV M-extension unit: shift-add multiply and restoring divide, one step per cycle.
// Optional MDU_DIV_BYPASS_EN finishes divide-by-zero and signed overflow at the accept edge.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int unsigned DW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic             out_valid_d;
    logic [XLEN-1:0]  result_d;
    logic [TAG_W-1:0] tag_d;

    op_e             op_in;
    logic            accept, sign_a, sign_b, b_zero, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;

    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Operand magnitudes and the sign the final result must carry.
    assign op_in  = op_e'(in_op);
    assign sign_a = a_signed(op_in) & in_a[XLEN-1];
    assign sign_b = b_signed(op_in) & in_b[XLEN-1];
    assign mag_a  = sign_a ? -in_a : in_a;
    assign mag_b  = sign_b ? -in_b : in_b;
    assign b_zero = (in_b == '0);
    // Divide-by-zero quotient must stay all ones, so it is never negated.
    assign neg_in = is_mul(op_in) ? (sign_a ^ sign_b)
                  : is_rem(op_in) ? sign_a
                  : ((sign_a ^ sign_b) & ~b_zero);

    logic [XLEN:0]   mul_sum;
    logic [DW-1:0]   mul_nxt, acc_step;
    logic [XLEN-1:0] rem_nxt, quo_nxt;

    assign mul_sum = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem     (acc_q[DW-1:XLEN]),
        .quo     (acc_q[XLEN-1:0]),
        .div     (b_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    assign acc_step = is_mul(op_q) ? mul_nxt : {rem_nxt, quo_nxt};

    logic [DW-1:0]   prod_s;
    logic [XLEN-1:0] div_sel, div_s, res_c;

    assign prod_s  = neg_q ? -acc_step : acc_step;
    assign div_sel = is_rem(op_q) ? acc_step[DW-1:XLEN] : acc_step[XLEN-1:0];
    assign div_s   = neg_q ? -div_sel : div_sel;
    assign res_c   = ~is_mul(op_q)      ? div_s
                   : (op_q == OP_MUL)   ? prod_s[XLEN-1:0]
                   : prod_s[DW-1:XLEN];

`ifdef MDU_DIV_BYPASS_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic            byp_c;
    logic [XLEN-1:0] byp_res;

    assign byp_c   = ~is_mul(op_in) & (b_zero | (a_signed(op_in) & (in_a == INT_MIN) & (&in_b)));
    assign byp_res = is_rem(op_in) ? (b_zero ? in_a : '0) : (b_zero ? '1 : in_a);
`endif

    // Next-state and datapath load logic; flush overrides accept and completion.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        b_d         = b_q;
        acc_d       = acc_q;
        out_valid_d = out_valid;
        result_d    = out_result;
        tag_d       = out_tag;

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = res_c;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                state_d     = CALC;
                out_valid_d = 1'b0;
                op_d        = op_in;
                cnt_d       = CNT_W'(XLEN);
                neg_d       = neg_in;
                b_d         = mag_b;
                acc_d       = {{XLEN{1'b0}}, mag_a};
                tag_d       = in_tag;
`ifdef MDU_DIV_BYPASS_EN
                if (byp_c) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = byp_res;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_MUL;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            b_q        <= '0;
            acc_q      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            out_valid  <= out_valid_d;
            out_result <= result_d;
            out_tag    <= tag_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed RV M-extension cases, backpressure,
// flush, async reset and randomized ops against a 64-bit arithmetic reference.
module tb_mdu_seq;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;
`ifdef MDU_DIV_BYPASS_EN
    // Bypassed specials are already valid right after the accept edge.
    localparam int BYP_LAT = 0;
`else
    localparam int BYP_LAT = XLEN;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int total  = 0;
    int passed = 0;

    mdu_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: RV M-extension semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'h0, b}); r = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return special ? BYP_LAT : XLEN;
    endfunction

    // Present a request until accepted; all tasks enter and leave at posedge+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, output int n);
        logic rdy;
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        n = 0;
        do begin
            #3;
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp);
        int na, n;
        issue(op, a, b, tag, na);
        wait_done(n);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_res"}, out_result, exp);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        chk({name, "_lat"}, 32'(n), 32'(exp_lat(op, a, b)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, na, seen;
        logic [31:0] held;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int sel;

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB);
        run_op("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 4'd1, 32'h4000_0000);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'd2, 32'hFFFF_FFFE);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFF);
        run_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         4'd4, 32'hFFFF_FFFD);
        run_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         4'd6, 32'hFFFF_FFFF);
        run_op("divu",    3'd5, 32'd100,        32'd7,         4'd7, 32'd14);
        run_op("remu",    3'd7, 32'd100,        32'd7,         4'd8, 32'd2);
        run_op("div0",    3'd4, 32'd5,          32'd0,         4'd9, 32'hFFFF_FFFF);
        run_op("rem0",    3'd6, 32'd5,          32'd0,         4'd10, 32'd5);
        run_op("divovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 4'd11, 32'h8000_0000);
        run_op("removf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 4'd12, 32'd0);

        // Backpressure: result and tag hold while the consumer stalls.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 4'd13, na);
        wait_done(n);
        held = ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        chk("bp_lat", 32'(n), 32'(XLEN));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_res", out_result, held);
            chk("bp_tag", 32'(out_tag), 32'd13);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        issue(3'd5, 32'd1000, 32'd33, 4'd14, na);
        chk("bp_same_edge_accept", 32'(na), 32'd1);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        wait_done(n);
        chk("bp_next_lat", 32'(n), 32'(XLEN));
        chk("bp_next_res", out_result, 32'd30);
        chk("bp_next_tag", 32'(out_tag), 32'd14);

        // Async reset mid-CALC clears outputs before any edge.
        @(posedge clk);
        #1;
        issue(3'd1, 32'h7FFF_0000, 32'h0003_0000, 4'd15, na);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_result", out_result, 32'd0);
        chk("arst_out_tag", 32'(out_tag), 32'd0);
        #5 rst_n = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Flush at CALC iteration 10 kills the op.
        issue(3'd5, 32'hFFFF_0000, 32'd3, 4'd2, na);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("flush_no_result", 32'(seen), 32'd0);

        // A request presented together with flush is dropped.
        in_op = 3'd0; in_a = 32'd3; in_b = 32'd4; in_tag = 4'd3;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("flush_acc_no_result", 32'(seen), 32'd0);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 7);
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = '0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
            if (sel == 3) ra = -ra;
            run_op("rnd", rop, ra, rb, 4'($urandom), ref_model(rop, ra, rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
